// File: rtl/prom_loader_if.sv
`default_nettype none
//==== prom_loader_if : byte-load stream, status and fetch port of prom_loader (rev 1.0) ====
interface prom_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 15
);
  logic              START;
  logic [7:0]        RX_DATA;
  logic              RX_VALID;
  logic              RX_READY;
  logic              BUSY;
  logic              DONE;
  logic              ERR;
  logic [ADDR_W-1:0] P_COUNT;
  logic [DATA_W-1:0] PROM_OUT;

  modport master (
    output START, RX_DATA, RX_VALID, P_COUNT,
    input  RX_READY, BUSY, DONE, ERR, PROM_OUT
  );

  modport slave (
    input  START, RX_DATA, RX_VALID, P_COUNT,
    output RX_READY, BUSY, DONE, ERR, PROM_OUT
  );
endinterface
`default_nettype wire

// File: rtl/prom_loader.sv
`default_nettype none
//==== prom_loader : byte-stream loaded 256x15 program memory with 1-cycle fetch port (rev 1.0) ====
module prom_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 15,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  wire logic      CLK,
  input  wire logic      RST,
  prom_loader_if.slave   bus
);

  localparam int HI_W = DATA_W - 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_HI    = 3'd2,
    S_LO    = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic              rx_ready_q, rx_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [8:0]        remaining_q, remaining_d;
  logic [HI_W-1:0]   hi_q, hi_d;
  logic [7:0]        lo_q, lo_d;
  logic [DATA_W-1:0] prom_out_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              xfer;
  logic              mem_we;

  assign xfer   = bus.RX_VALID & rx_ready_q;
  assign mem_we = (state_q == S_WRITE);

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = done_q;
    err_d       = err_q;
    wptr_d      = wptr_q;
    remaining_d = remaining_q;
    hi_d        = hi_q;
    lo_d        = lo_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (bus.START) begin
          state_d = S_LEN;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
          wptr_d  = '0;
        end
      end
      S_LEN: begin
        if (xfer) begin
          // a zero header encodes a full 256-word image
          remaining_d = (bus.RX_DATA == 8'h00) ? 9'd256 : {1'b0, bus.RX_DATA};
          state_d     = S_HI;
        end
      end
      S_HI: begin
        if (xfer) begin
          if (bus.RX_DATA[7]) begin
            state_d = S_ERR;
            busy_d  = 1'b0;
            err_d   = 1'b1;
          end else begin
            hi_d    = bus.RX_DATA[HI_W-1:0];
            state_d = S_LO;
          end
        end
      end
      S_LO: begin
        if (xfer) begin
          lo_d    = bus.RX_DATA;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        wptr_d      = wptr_q + ADDR_W'(1);
        remaining_d = remaining_q - 9'd1;
        if (remaining_q == 9'd1) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = S_HI;
        end
      end
      default: state_d = S_IDLE;
    endcase

    rx_ready_d = (state_d == S_LEN) || (state_d == S_HI) || (state_d == S_LO);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      rx_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      wptr_q      <= '0;
      remaining_q <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      prom_out_q  <= '0;
    end else begin
      state_q     <= state_d;
      rx_ready_q  <= rx_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      wptr_q      <= wptr_d;
      remaining_q <= remaining_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      prom_out_q  <= mem[bus.P_COUNT];
    end
  end

  // Contents survive reset; a colliding fetch sees the pre-write word.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[wptr_q] <= {hi_q, lo_q};
    end
  end

  assign bus.RX_READY = rx_ready_q;
  assign bus.BUSY     = busy_q;
  assign bus.DONE     = done_q;
  assign bus.ERR      = err_q;
  assign bus.PROM_OUT = prom_out_q;

endmodule
`default_nettype wire

// File: tb/tb_prom_loader.sv
`default_nettype none
//==== tb_prom_loader : randomized self-checking bench for prom_loader (rev 1.0) ====
module tb_prom_loader;

  typedef logic [7:0]  bq_t [$];
  typedef logic [14:0] wq_t [$];

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  prom_loader_if bus ();

  prom_loader dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  // reference image: value and whether the bench knows it
  logic [14:0] m_mem   [256];
  bit          m_known [256];
  int          last_waddr;
  logic [14:0] last_old;
  bit          last_known;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Applies a byte stream to the reference image; 0=done, 1=format error, 2=incomplete
  function automatic int model_load(input bq_t b);
    int n, i, a;
    last_waddr = -1;
    if (b.size() == 0) return 2;
    n = (b[0] == 8'h00) ? 256 : int'(b[0]);
    i = 1;
    a = 0;
    for (int w = 0; w < n; w++) begin
      if (i >= b.size()) return 2;
      if (b[i][7]) return 1;
      if (i + 1 >= b.size()) return 2;
      last_waddr = a;
      last_old   = m_mem[a];
      last_known = m_known[a];
      m_mem[a]   = {b[i][6:0], b[i+1]};
      m_known[a] = 1'b1;
      a = (a + 1) % 256;
      i += 2;
    end
    return 0;
  endfunction

  function automatic bq_t words_to_bytes(input wq_t w);
    bq_t b;
    b.push_back((w.size() == 256) ? 8'h00 : 8'(w.size()));
    foreach (w[i]) begin
      b.push_back({1'b0, w[i][14:8]});
      b.push_back(w[i][7:0]);
    end
    return b;
  endfunction

  task automatic run_load(input bq_t b, input int gapmax, input int glitch, input int pc,
                          input int abort_at);
    bq_t         sent;
    int          st, t;
    logic [14:0] fin_exp;
    bit          fin_known;

    if (abort_at >= 0) begin
      for (int k = 0; k < abort_at; k++) sent.push_back(b[k]);
    end else begin
      sent = b;
    end
    bus.P_COUNT = 8'(pc);
    st = model_load(sent);
    if (last_waddr == pc) begin
      fin_exp = last_old;   fin_known = last_known;
    end else begin
      fin_exp = m_mem[pc];  fin_known = m_known[pc];
    end

    check("busy_before_start", bus.BUSY, 0);
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    check("busy_after_start", bus.BUSY, 1);
    check("done_after_start", bus.DONE, 0);
    check("err_after_start", bus.ERR, 0);

    for (int k = 0; k < sent.size(); k++) begin
      repeat ($urandom_range(0, gapmax)) begin
        bus.RX_VALID = 1'b0;
        bus.RX_DATA  = 8'($urandom);
        tick();
      end
      bus.RX_VALID = 1'b1;
      bus.RX_DATA  = sent[k];
      if (k == glitch) bus.START = 1'b1;
      t = 0;
      while (!bus.RX_READY && t < 20) begin
        tick();
        t++;
      end
      if (t >= 20) begin
        check("ready_timeout", 0, 1);
        bus.RX_VALID = 1'b0;
        bus.START    = 1'b0;
        return;
      end
      tick();
      bus.START = 1'b0;
      if (k >= 2 && (k % 2) == 0) check("ready_in_write", bus.RX_READY, 0);
    end
    bus.RX_VALID = 1'b0;
    if (abort_at >= 0) return;

    if (st == 1) begin
      check("err_flag", bus.ERR, 1);
      check("err_busy", bus.BUSY, 0);
      check("err_done", bus.DONE, 0);
    end else begin
      check("busy_in_last_write", bus.BUSY, 1);
      tick();
      check("done_flag", bus.DONE, 1);
      check("done_busy", bus.BUSY, 0);
      check("done_err", bus.ERR, 0);
      if (fin_known) check("read_on_write_edge", bus.PROM_OUT, fin_exp);
      tick();
      if (m_known[pc]) check("read_after_write", bus.PROM_OUT, m_mem[pc]);
    end
  endtask

  task automatic readall();
    for (int a = 0; a < 256; a++) begin
      if (m_known[a]) begin
        bus.P_COUNT = 8'(a);
        tick();
        check($sformatf("mem[%0d]", a), bus.PROM_OUT, m_mem[a]);
      end
    end
  endtask

  initial begin
    bq_t b;
    wq_t w;
    int  n, e;

    bus.START    = 1'b0;
    bus.RX_VALID = 1'b0;
    bus.RX_DATA  = 8'h00;
    bus.P_COUNT  = 8'h00;
    foreach (m_known[i]) begin
      m_known[i] = 1'b0;
      m_mem[i]   = 15'h0;
    end
    rst = 1'b1;
    #1;
    check("rst_ready", bus.RX_READY, 0);
    check("rst_busy", bus.BUSY, 0);
    check("rst_done", bus.DONE, 0);
    check("rst_err", bus.ERR, 0);
    check("rst_prom_out", bus.PROM_OUT, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // directed two-word load, valid held high
    w = '{15'h4800, 15'h4020};
    b = words_to_bytes(w);
    run_load(b, 0, -1, 0, -1);
    readall();

    // three words with random valid gaps
    w = '{};
    repeat (3) w.push_back(15'($urandom));
    run_load(words_to_bytes(w), 3, -1, 2, -1);
    readall();

    // format error on the second word
    b = '{8'h03, 8'h12, 8'h34, 8'h80};
    run_load(b, 2, -1, 1, -1);
    readall();

    // full 256-word image, word value = address
    w = '{};
    for (int a = 0; a < 256; a++) w.push_back(15'(a));
    run_load(words_to_bytes(w), 0, -1, 255, -1);
    readall();

    // reset after the high byte of word 1, then reload with a START glitch in HI
    w = '{};
    repeat (3) w.push_back(15'($urandom));
    b = words_to_bytes(w);
    run_load(b, 1, -1, 0, 4);
    rst = 1'b1;
    #1;
    check("midrst_ready", bus.RX_READY, 0);
    check("midrst_busy", bus.BUSY, 0);
    check("midrst_done", bus.DONE, 0);
    check("midrst_err", bus.ERR, 0);
    check("midrst_prom_out", bus.PROM_OUT, 0);
    tick();
    rst = 1'b0;
    readall();
    run_load(b, 1, 3, 1, -1);
    readall();

    // read/write collision on address 5
    w = '{};
    repeat (6) w.push_back(15'($urandom));
    w[5] = 15'h7FFF;
    run_load(words_to_bytes(w), 1, -1, 0, -1);
    w[5] = 15'h0001;
    run_load(words_to_bytes(w), 0, -1, 5, -1);
    readall();

    // random loads, some with a format error
    repeat (6) begin
      n = $urandom_range(1, 12);
      b = '{8'(n)};
      e = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : n;
      for (int i = 0; i < e; i++) begin
        b.push_back(8'($urandom_range(0, 127)));
        b.push_back(8'($urandom));
      end
      if (e < n) b.push_back(8'($urandom_range(128, 255)));
      run_load(b, 3, -1, $urandom_range(0, n - 1), -1);
    end
    readall();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
